// File: rtl/camera_pkg.sv
// Shared definitions for the windowed camera capture path: FSM encoding,
// FIFO entry layout and default sensor geometry.
package camera_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_ACTIVE     = 2'd2
    } cap_state_e;

    // A FIFO entry is {sync, eol, data}; flags sit directly above the pixel data.
    localparam int ENTRY_FLAG_W = 2;

    function automatic int entry_eol_bit(input int data_w);
        return data_w;
    endfunction

    function automatic int entry_sync_bit(input int data_w);
        return data_w + 1;
    endfunction

    localparam int DEFAULT_FRAME_W = 640;
    localparam int DEFAULT_FRAME_H = 480;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with head-of-queue read; a write into a full FIFO is
// accepted only when a read frees a slot in the same cycle.
module pixel_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             wr_ok_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_rd;
    logic             do_wr;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign do_rd     = rd_en_i & ~empty_o;
    assign do_wr     = wr_en_i & (~full_o | do_rd);
    assign wr_ok_o   = do_wr;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_wr && !do_rd) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (do_rd && !do_wr) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/camera_capture_win.sv
// Oversampled camera parallel-bus capture: pixel assembly, window crop and
// a ready/valid output stream with frame-start / end-of-line markers.
module camera_capture_win
    import camera_pkg::*;
#(
    parameter  int PIX_BYTES   = 2,
    parameter  int FIFO_DEPTH  = 16,
    parameter  int COORD_W     = 12,
    parameter  int SYNC_STAGES = 2,
    parameter  int FCNT_W      = 16,
    localparam int DATA_W      = 8 * PIX_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [COORD_W-1:0] win_x,
    input  logic [COORD_W-1:0] win_y,
    input  logic [COORD_W-1:0] win_w,
    input  logic [COORD_W-1:0] win_h,
    input  logic              img_ready,
    output logic              img_valid,
    output logic              img_sync,
    output logic              img_eol,
    output logic [DATA_W-1:0] img_data,
    output logic [FCNT_W-1:0] frame_count,
    output logic              overflow,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_hsync,
    input  logic [7:0]        cam_data
);
    localparam int IDX_W   = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
    localparam int SYNC_W  = 11;
    localparam int ENTRY_W = DATA_W + ENTRY_FLAG_W;
    localparam int EOL_BIT = entry_eol_bit(DATA_W);
    localparam int SYN_BIT = entry_sync_bit(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_BYTES - 1);

    // pclk, vsync, hsync and data share one chain so they stay aligned.
    logic [SYNC_W-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= {cam_pclk, cam_vsync, cam_hsync, cam_data};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    logic       pclk_s, vsync_s, hsync_s;
    logic [7:0] data_s;
    assign pclk_s  = sync_q[SYNC_STAGES-1][10];
    assign vsync_s = sync_q[SYNC_STAGES-1][9];
    assign hsync_s = sync_q[SYNC_STAGES-1][8];
    assign data_s  = sync_q[SYNC_STAGES-1][7:0];

    cap_state_e         state_q;
    logic               pclk_prev_q, vsync_prev_q, hsync_prev_q;
    logic [COORD_W-1:0] x_q, y_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  acc_q;
    logic [COORD_W-1:0] win_x_q, win_y_q, win_w_q, win_h_q;
    logic               sync_pending_q;
    logic               pix_done_q;
    logic [COORD_W-1:0] pix_x_q, pix_y_q;
    logic [DATA_W-1:0]  pix_data_q;
    logic               push_q;
    logic               ent_eol_q;
    logic [DATA_W-1:0]  ent_data_q;
    logic [FCNT_W-1:0]  frame_count_q;
    logic               overflow_q;

    logic pclk_rise, vsync_rise, vsync_fall, hsync_fall;
    assign pclk_rise  = pclk_s & ~pclk_prev_q;
    assign vsync_rise = vsync_s & ~vsync_prev_q;
    assign vsync_fall = ~vsync_s & vsync_prev_q;
    assign hsync_fall = ~hsync_s & hsync_prev_q;

    logic [DATA_W+7:0] acc_wide;
    logic [DATA_W-1:0] acc_d;
    assign acc_wide = {acc_q, data_s};
    assign acc_d    = acc_wide[DATA_W-1:0];

    // One extra bit so win_x+win_w never wraps back into the frame.
    logic [COORD_W:0] x_ext, y_ext, wx_ext, wy_ext, wx_end, wy_end;
    logic             in_win, is_eol;
    assign x_ext  = {1'b0, pix_x_q};
    assign y_ext  = {1'b0, pix_y_q};
    assign wx_ext = {1'b0, win_x_q};
    assign wy_ext = {1'b0, win_y_q};
    assign wx_end = wx_ext + {1'b0, win_w_q};
    assign wy_end = wy_ext + {1'b0, win_h_q};
    assign in_win = (x_ext >= wx_ext) && (x_ext < wx_end) &&
                    (y_ext >= wy_ext) && (y_ext < wy_end);
    assign is_eol = (x_ext == wx_end - (COORD_W+1)'(1));

    logic               fifo_wr_en, fifo_wr_ok, fifo_full, fifo_empty, fifo_rd;
    logic [ENTRY_W-1:0] fifo_wr_data, fifo_head;
    assign fifo_wr_en   = push_q & enable;
    assign fifo_wr_data = {sync_pending_q, ent_eol_q, ent_data_q};
    assign fifo_rd      = img_ready & ~fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            pclk_prev_q    <= 1'b0;
            vsync_prev_q   <= 1'b0;
            hsync_prev_q   <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            idx_q          <= '0;
            acc_q          <= '0;
            win_x_q        <= '0;
            win_y_q        <= '0;
            win_w_q        <= '0;
            win_h_q        <= '0;
            sync_pending_q <= 1'b0;
            pix_done_q     <= 1'b0;
            pix_x_q        <= '0;
            pix_y_q        <= '0;
            pix_data_q     <= '0;
            push_q         <= 1'b0;
            ent_eol_q      <= 1'b0;
            ent_data_q     <= '0;
            frame_count_q  <= '0;
            overflow_q     <= 1'b0;
        end else begin
            pclk_prev_q  <= pclk_s;
            vsync_prev_q <= vsync_s;
            hsync_prev_q <= hsync_s;
            if (!enable) begin
                state_q    <= ST_IDLE;
                overflow_q <= 1'b0;
                pix_done_q <= 1'b0;
                push_q     <= 1'b0;
                idx_q      <= '0;
            end else begin
                pix_done_q <= 1'b0;
                push_q     <= pix_done_q & in_win;
                ent_eol_q  <= is_eol;
                ent_data_q <= pix_data_q;
                if (push_q && !fifo_wr_ok) begin
                    overflow_q <= 1'b1;
                end
                // Only an accepted pixel consumes the frame-start marker.
                if (fifo_wr_ok) begin
                    sync_pending_q <= 1'b0;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (vsync_rise) begin
                            state_q <= ST_WAIT_FRAME;
                        end
                    end
                    ST_WAIT_FRAME: begin
                        if (vsync_fall) begin
                            state_q        <= ST_ACTIVE;
                            x_q            <= '0;
                            y_q            <= '0;
                            idx_q          <= '0;
                            sync_pending_q <= 1'b1;
                            win_x_q        <= win_x;
                            win_y_q        <= win_y;
                            win_w_q        <= win_w;
                            win_h_q        <= win_h;
                        end
                    end
                    ST_ACTIVE: begin
                        if (vsync_rise) begin
                            state_q       <= ST_WAIT_FRAME;
                            frame_count_q <= frame_count_q + FCNT_W'(1);
                        end else if (pclk_rise && hsync_s) begin
                            acc_q <= acc_d;
                            if (idx_q == LAST_IDX) begin
                                idx_q      <= '0;
                                x_q        <= x_q + COORD_W'(1);
                                pix_done_q <= 1'b1;
                                pix_x_q    <= x_q;
                                pix_y_q    <= y_q;
                                pix_data_q <= acc_d;
                            end else begin
                                idx_q <= idx_q + IDX_W'(1);
                            end
                        end else if (hsync_fall && (x_q != '0 || idx_q != '0)) begin
                            y_q   <= y_q + COORD_W'(1);
                            x_q   <= '0;
                            idx_q <= '0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    pixel_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .wr_en_i   (fifo_wr_en),
        .wr_data_i (fifo_wr_data),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .wr_ok_o   (fifo_wr_ok)
    );

    assign img_valid   = ~fifo_empty;
    assign img_sync    = fifo_head[SYN_BIT] & ~fifo_empty;
    assign img_eol     = fifo_head[EOL_BIT] & ~fifo_empty;
    assign img_data    = fifo_head[DATA_W-1:0] & {DATA_W{~fifo_empty}};
    assign frame_count = frame_count_q;
    assign overflow    = overflow_q;

endmodule
